// File: rtl/bullet_ctrl_if.sv
// bullet_ctrl_if
//   Groups the signals exchanged between the bullet generator and the rest of
//   the game: raster position from the sync generator, player controls and
//   ship position, the obstacle hit flag, and the bullet position/pixel
//   outputs consumed by the obstacle blocks and the display mux.
//   Modports:
//     slave  - the bullet generator (consumes raster/controls, drives bullet)
//     master - the environment around it (drives raster/controls, reads bullet)
interface bullet_ctrl_if;
  logic        video_on;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        fire;
  logic [10:0] ship_x;
  logic [10:0] ship_y;
  logic        hit;
  logic [10:0] bull_x;
  logic [10:0] bull_y;
  logic        bull_act;
  logic        bull_on;
  logic [2:0]  rgb;
  logic [7:0]  shot_cnt;

  modport slave (
    input  video_on, pix_x, pix_y, fire, ship_x, ship_y, hit,
    output bull_x, bull_y, bull_act, bull_on, rgb, shot_cnt
  );

  modport master (
    output video_on, pix_x, pix_y, fire, ship_x, ship_y, hit,
    input  bull_x, bull_y, bull_act, bull_on, rgb, shot_cnt
  );
endinterface

// File: rtl/bullet_ctrl.sv
// bullet_ctrl
//   Player bullet generator for the 640x480 space shooter. A fire press in
//   IDLE launches one bullet from the ship; the bullet climbs BULL_V pixels per
//   frame until it hits an obstacle or leaves the top of the screen, then the
//   block waits COOL_FRAMES frames before it will accept another press.
//   Ports:
//     clk    - system/pixel clock
//     reset  - synchronous, active-high
//     bus    - bullet_ctrl_if.slave:
//                in : video_on, pix_x, pix_y, fire, ship_x, ship_y, hit
//                out: bull_x, bull_y (tip position, PARK when inactive),
//                     bull_act (in flight), bull_on (pixel inside bullet),
//                     rgb (bullet colour), shot_cnt (launch count, wraps)
module bullet_ctrl #(
  parameter int BULL_V      = 4,
  parameter int BULL_W      = 2,
  parameter int BULL_H      = 6,
  parameter int COOL_FRAMES = 8,
  parameter int PARK        = 2047
) (
  input  logic          clk,
  input  logic          reset,
  bullet_ctrl_if.slave  bus
);

  localparam logic [10:0] PARK_POS = 11'(PARK);
  localparam logic [10:0] STEP_V   = 11'(BULL_V);
  localparam logic [10:0] HEIGHT   = 11'(BULL_H);
  localparam int          CNT_W    = $clog2(COOL_FRAMES + 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIGHT   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [10:0]      bull_x_q, bull_x_d;
  logic [10:0]      bull_y_q, bull_y_d;
  logic [7:0]       shot_cnt_q, shot_cnt_d;
  logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;
  logic             fire_q;

  logic frame_tick;
  logic fire_rise;

  // One pulse per frame, placed just below the visible area so the bullet
  // moves while nothing is being drawn.
  assign frame_tick = (bus.pix_y == 11'd481) && (bus.pix_x == 11'd0);
  assign fire_rise  = bus.fire & ~fire_q;

  // State and datapath registers. fire_q resets to 1 so a button already held
  // when reset releases is not seen as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bull_x_q   <= PARK_POS;
      bull_y_q   <= PARK_POS;
      shot_cnt_q <= 8'd0;
      cool_cnt_q <= '0;
      fire_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bull_x_q   <= bull_x_d;
      bull_y_q   <= bull_y_d;
      shot_cnt_q <= shot_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      fire_q     <= bus.fire;
    end
  end

  // Next-state and datapath updates. Presses outside IDLE and hits outside
  // FLIGHT fall through the defaults and are simply dropped.
  always_comb begin
    state_d    = state_q;
    bull_x_d   = bull_x_q;
    bull_y_d   = bull_y_q;
    shot_cnt_d = shot_cnt_q;
    cool_cnt_d = cool_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (fire_rise) begin
          state_d    = FLIGHT;
          bull_x_d   = bus.ship_x;
          // Clamp at row 0 when the ship sits too close to the top.
          bull_y_d   = (bus.ship_y >= HEIGHT) ? (bus.ship_y - HEIGHT) : 11'd0;
          shot_cnt_d = shot_cnt_q + 8'd1;
        end
      end

      FLIGHT: begin
        // A hit wins over movement so the bullet is not advanced on the
        // frame it collides.
        if (bus.hit || (frame_tick && (bull_y_q < STEP_V))) begin
          state_d    = COOLDOWN;
          bull_x_d   = PARK_POS;
          bull_y_d   = PARK_POS;
          cool_cnt_d = '0;
        end else if (frame_tick) begin
          bull_y_d = bull_y_q - STEP_V;
        end
      end

      COOLDOWN: begin
        if (frame_tick) begin
          if (cool_cnt_q == COOL_LAST) begin
            state_d    = IDLE;
            cool_cnt_d = '0;
          end else begin
            cool_cnt_d = cool_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        bull_x_d = PARK_POS;
        bull_y_d = PARK_POS;
      end
    endcase
  end

  // Pixel test is done in 12 bits so bull_x+BULL_W cannot wrap near the
  // parked position.
  logic [11:0] x_lo, x_hi, y_lo, y_hi, px, py;

  always_comb begin
    x_lo = {1'b0, bull_x_q};
    y_lo = {1'b0, bull_y_q};
    x_hi = x_lo + 12'(BULL_W);
    y_hi = y_lo + 12'(BULL_H);
    px   = {1'b0, bus.pix_x};
    py   = {1'b0, bus.pix_y};
  end

  assign bus.bull_act = (state_q == FLIGHT);
  assign bus.bull_on  = bus.bull_act && (px >= x_lo) && (px < x_hi) &&
                        (py >= y_lo) && (py < y_hi);
  assign bus.rgb      = (bus.video_on && bus.bull_on) ? 3'b100 : 3'b000;
  assign bus.bull_x   = bull_x_q;
  assign bus.bull_y   = bull_y_q;
  assign bus.shot_cnt = shot_cnt_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// tb_bullet_ctrl
//   Directed bench for bullet_ctrl: reset with fire held, launch position,
//   per-frame climb, hit priority, top-of-screen exit, cooldown and press
//   rejection, pixel/colour window, shot counter wrap and reset mid-flight.
module tb_bullet_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bullet_ctrl_if bus ();

  bullet_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs changed afterwards settle well before the next
  // edge and outputs are sampled away from it.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame tick: raster sits on (0,481) for a single clock.
  task automatic frameTick();
    bus.pix_x = 11'd0;
    bus.pix_y = 11'd481;
    applyStimulus(1);
    bus.pix_y = 11'd0;
  endtask

  // Press and release the fire button.
  task automatic pressFire();
    bus.fire = 1'b1;
    applyStimulus(1);
    bus.fire = 1'b0;
    applyStimulus(1);
  endtask

  // Run the cooldown out with the given number of frame ticks.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) frameTick();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.video_on  = 1'b0;
    bus.pix_x     = 11'd0;
    bus.pix_y     = 11'd0;
    bus.fire      = 1'b1;
    bus.ship_x    = 11'd320;
    bus.ship_y    = 11'd440;
    bus.hit       = 1'b0;

    // 1: reset with fire held, then release and press.
    applyStimulus(2);
    checkOutput("rst_act", 32'(bus.bull_act), 32'd0);
    checkOutput("rst_x", 32'(bus.bull_x), 32'd2047);
    checkOutput("rst_y", 32'(bus.bull_y), 32'd2047);
    checkOutput("rst_cnt", 32'(bus.shot_cnt), 32'd0);
    reset = 1'b0;
    applyStimulus(3);
    checkOutput("held_no_fire", 32'(bus.bull_act), 32'd0);
    checkOutput("held_cnt", 32'(bus.shot_cnt), 32'd0);
    bus.fire = 1'b0;
    applyStimulus(1);
    bus.fire = 1'b1;
    applyStimulus(1);
    checkOutput("launch_act", 32'(bus.bull_act), 32'd1);
    checkOutput("launch_cnt", 32'(bus.shot_cnt), 32'd1);

    // 2: launch position and three frames of climb; holding fire does nothing.
    checkOutput("launch_x", 32'(bus.bull_x), 32'd320);
    checkOutput("launch_y", 32'(bus.bull_y), 32'd434);
    applyStimulus(4);
    checkOutput("hold_no_repeat", 32'(bus.shot_cnt), 32'd1);
    bus.fire = 1'b0;
    ticks(3);
    checkOutput("climb_y", 32'(bus.bull_y), 32'd422);
    checkOutput("climb_x", 32'(bus.bull_x), 32'd320);

    // 3: hit coinciding with a frame tick ends the flight without a step.
    bus.hit = 1'b1;
    frameTick();
    bus.hit = 1'b0;
    checkOutput("hit_act", 32'(bus.bull_act), 32'd0);
    checkOutput("hit_park_x", 32'(bus.bull_x), 32'd2047);
    checkOutput("hit_park_y", 32'(bus.bull_y), 32'd2047);

    // Press during cooldown is discarded; cooldown lasts exactly 8 ticks.
    pressFire();
    checkOutput("cool_press_ign", 32'(bus.shot_cnt), 32'd1);
    ticks(7);
    pressFire();
    checkOutput("cool7_press_ign", 32'(bus.shot_cnt), 32'd1);
    checkOutput("cool7_act", 32'(bus.bull_act), 32'd0);
    ticks(1);
    bus.hit = 1'b1;
    applyStimulus(1);
    bus.hit = 1'b0;
    checkOutput("idle_hit_ign", 32'(bus.bull_y), 32'd2047);

    // 4: launch near the top; the next tick sees bull_y<BULL_V and exits.
    bus.ship_y = 11'd9;
    pressFire();
    checkOutput("top_launch_y", 32'(bus.bull_y), 32'd3);
    checkOutput("top_launch_cnt", 32'(bus.shot_cnt), 32'd2);
    ticks(1);
    checkOutput("top_exit_act", 32'(bus.bull_act), 32'd0);
    checkOutput("top_exit_y", 32'(bus.bull_y), 32'd2047);
    ticks(8);
    bus.ship_y = 11'd3;
    pressFire();
    checkOutput("clamp_y", 32'(bus.bull_y), 32'd0);
    bus.hit = 1'b1;
    applyStimulus(1);
    bus.hit = 1'b0;
    ticks(8);

    // 5: pixel window and colour for a bullet at (100,200).
    bus.ship_x = 11'd100;
    bus.ship_y = 11'd206;
    pressFire();
    checkOutput("pix_bull_y", 32'(bus.bull_y), 32'd200);
    bus.video_on = 1'b1;
    bus.pix_x = 11'd101; bus.pix_y = 11'd205; #1;
    checkOutput("pix_in_rgb", 32'(bus.rgb), 32'd4);
    checkOutput("pix_in_on", 32'(bus.bull_on), 32'd1);
    bus.pix_x = 11'd102; #1;
    checkOutput("pix_right_rgb", 32'(bus.rgb), 32'd0);
    bus.pix_x = 11'd100; bus.pix_y = 11'd199; #1;
    checkOutput("pix_above_on", 32'(bus.bull_on), 32'd0);
    bus.pix_y = 11'd206; #1;
    checkOutput("pix_below_on", 32'(bus.bull_on), 32'd0);
    bus.pix_x = 11'd101; bus.pix_y = 11'd205; bus.video_on = 1'b0; #1;
    checkOutput("pix_blank_rgb", 32'(bus.rgb), 32'd0);
    checkOutput("pix_blank_on", 32'(bus.bull_on), 32'd1);
    bus.pix_x = 11'd0; bus.pix_y = 11'd0;

    // 6: from reset, 256 launches wrap the counter; then reset mid-flight.
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    applyStimulus(1);
    for (int n = 0; n < 255; n++) begin
      pressFire();
      bus.hit = 1'b1;
      applyStimulus(1);
      bus.hit = 1'b0;
      ticks(8);
    end
    checkOutput("cnt_255", 32'(bus.shot_cnt), 32'd255);
    pressFire();
    checkOutput("cnt_wrap", 32'(bus.shot_cnt), 32'd0);
    checkOutput("wrap_act", 32'(bus.bull_act), 32'd1);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("midrst_act", 32'(bus.bull_act), 32'd0);
    checkOutput("midrst_x", 32'(bus.bull_x), 32'd2047);
    checkOutput("midrst_y", 32'(bus.bull_y), 32'd2047);
    checkOutput("midrst_cnt", 32'(bus.shot_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
